// File: rtl/tone_if.sv
// rtl/tone_if.sv - note request handshake between the game sequencer and tone_player
interface tone_if #(
    parameter int DUR_W = 16
);
    logic [17:0]      note;
    logic [DUR_W-1:0] duration_ms;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;

    modport master (
        output note, duration_ms, start, stop,
        input  busy, done
    );

    modport slave (
        input  note, duration_ms, start, stop,
        output busy, done
    );
endinterface

// File: rtl/tone_player.sv
// rtl/tone_player.sv - plays one square-wave note for duration_ms, then a silent gap, then pulses done
module tone_player #(
    parameter int CLK_HZ       = 100000000,
    parameter int TICKS_PER_MS = CLK_HZ / 1000,
    parameter int DUR_W        = 16,
    parameter int GAP_MS       = 50
) (
    input  logic   clk,
    input  logic   reset,
    tone_if.slave  bus,
    output logic   speaker
);
    localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_MS - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);
    localparam bit               HAS_GAP   = (GAP_MS != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [16:0]      half;
    logic [16:0]      half_cnt;
    logic [DUR_W-1:0] dur;
    logic [DUR_W-1:0] ms_cnt;
    logic [TW-1:0]    ms_tick_cnt;

    logic ms_wrap;
    logic play_last;
    logic gap_last;

    assign ms_wrap   = (ms_tick_cnt == TICK_LAST);
    assign play_last = ms_wrap && (ms_cnt == dur - DUR_W'(1));
    assign gap_last  = ms_wrap && (ms_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            half        <= '0;
            half_cnt    <= '0;
            dur         <= '0;
            ms_cnt      <= '0;
            ms_tick_cnt <= '0;
            speaker     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        half        <= bus.note[17:1];
                        dur         <= bus.duration_ms;
                        half_cnt    <= '0;
                        ms_cnt      <= '0;
                        ms_tick_cnt <= '0;
                        speaker     <= 1'b0;
                        if (bus.duration_ms != '0) begin
                            state    <= PLAY;
                            bus.busy <= 1'b1;
                        end else if (HAS_GAP) begin
                            state    <= GAP;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end

                PLAY: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        speaker     <= 1'b0;
                        half_cnt    <= '0;
                        ms_cnt      <= '0;
                        ms_tick_cnt <= '0;
                    end else begin
                        ms_tick_cnt <= ms_wrap ? '0 : ms_tick_cnt + TW'(1);
                        // half == 0 is a rest: timing runs but the pin never toggles
                        if (half != '0) begin
                            if (half_cnt == half - 17'd1) begin
                                half_cnt <= '0;
                                speaker  <= ~speaker;
                            end else begin
                                half_cnt <= half_cnt + 17'd1;
                            end
                        end
                        if (play_last) begin
                            ms_cnt   <= '0;
                            half_cnt <= '0;
                            speaker  <= 1'b0;
                            if (HAS_GAP) begin
                                state <= GAP;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end
                        end else if (ms_wrap) begin
                            ms_cnt <= ms_cnt + DUR_W'(1);
                        end
                    end
                end

                GAP: begin
                    speaker <= 1'b0;
                    if (bus.stop) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        ms_cnt      <= '0;
                        ms_tick_cnt <= '0;
                    end else begin
                        ms_tick_cnt <= ms_wrap ? '0 : ms_tick_cnt + TW'(1);
                        if (gap_last) begin
                            state    <= IDLE;
                            ms_cnt   <= '0;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else if (ms_wrap) begin
                            ms_cnt <= ms_cnt + DUR_W'(1);
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    speaker  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tone_player.sv
// tb/tb_tone_player.sv - self-checking bench for tone_player against a per-cycle arithmetic reference
module tb_tone_player;
    localparam int T = 10;
    localparam int G = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spk0, spk1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tone_if #(.DUR_W(16)) if0 ();
    tone_if #(.DUR_W(16)) if1 ();

    tone_player #(.CLK_HZ(10000), .TICKS_PER_MS(T), .DUR_W(16), .GAP_MS(G)) u0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .speaker(spk0));

    tone_player #(.CLK_HZ(10000), .TICKS_PER_MS(T), .DUR_W(16), .GAP_MS(0)) u1 (
        .clk(clk), .reset(reset), .bus(if1.slave), .speaker(spk1));

    typedef struct {
        logic [17:0] note;
        logic [15:0] dur;
        int          stop_cyc;
        int          busy_start;
        int          exp_done;
        int          exp_rise;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {busy,done,speaker} k cycles after the start cycle, straight from the timing rules
    function automatic logic [2:0] model(input logic [17:0] n, input int d, input int gms,
                                         input int k, input int stop_cyc);
        int  h, play_len, total;
        logic b, dn, s;
        h        = int'(n >> 1);
        play_len = d * T;
        total    = play_len + gms * T;
        if (stop_cyc > 0 && k > stop_cyc) return 3'b000;
        b  = (k >= 1) && (k <= total);
        dn = (k == total + 1);
        s  = 1'b0;
        if (h > 0 && k >= 1 && k <= play_len) s = (((k - 1) / h) % 2) == 1;
        return {b, dn, s};
    endfunction

    task automatic play(input logic [17:0] n, input logic [15:0] d, input int stop_cyc,
                        input int busy_start, input bit chain, input logic [17:0] nn,
                        input logic [15:0] nd, input bit started,
                        output int done_at, output int rise_at);
        int total;
        logic [2:0] exp_v, act_v;
        total   = int'(d) * T + G * T;
        done_at = -1;
        rise_at = -1;
        if (!started) begin
            if0.note        = n;
            if0.duration_ms = d;
            if0.start       = 1'b1;
            @(posedge clk); #1;
        end
        for (int k = 1; k <= total + 1; k++) begin
            if0.start       = 1'b0;
            if0.stop        = (k == stop_cyc);
            if0.note        = 18'($urandom);
            if0.duration_ms = 16'($urandom);
            if (k == busy_start) begin
                if0.start       = 1'b1;
                if0.duration_ms = 16'($urandom_range(1, 3));
            end
            if (chain && k == total + 1) begin
                if0.start       = 1'b1;
                if0.note        = nn;
                if0.duration_ms = nd;
            end
            @(negedge clk);
            act_v = {if0.busy, if0.done, spk0};
            exp_v = model(n, int'(d), G, k, stop_cyc);
            chk($sformatf("cycle%0d_n%0d_d%0d", k, n, d), int'(act_v), int'(exp_v));
            if (if0.done && done_at < 0) done_at = k;
            if (spk0 && rise_at < 0) rise_at = k;
            @(posedge clk); #1;
        end
        if0.stop = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, rise_at, tot, sc, bs, dones;
        logic [17:0] rn;
        logic [15:0] rd;

        if0.note = '0; if0.duration_ms = '0; if0.start = 1'b0; if0.stop = 1'b0;
        if1.note = '0; if1.duration_ms = '0; if1.start = 1'b0; if1.stop = 1'b0;

        vecs[0] = '{note: 18'd8, dur: 16'd3, stop_cyc: 0,  busy_start: 0, exp_done: 41, exp_rise: 5};
        vecs[1] = '{note: 18'd0, dur: 16'd2, stop_cyc: 0,  busy_start: 0, exp_done: 31, exp_rise: -1};
        vecs[2] = '{note: 18'd9, dur: 16'd2, stop_cyc: 0,  busy_start: 0, exp_done: 31, exp_rise: 5};
        vecs[3] = '{note: 18'd9, dur: 16'd0, stop_cyc: 0,  busy_start: 0, exp_done: 11, exp_rise: -1};
        vecs[4] = '{note: 18'd8, dur: 16'd5, stop_cyc: 13, busy_start: 7, exp_done: -1, exp_rise: 5};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_u0", int'({if0.busy, if0.done, spk0}), 0);
        chk("reset_u1", int'({if1.busy, if1.done, spk1}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            play(vecs[i].note, vecs[i].dur, vecs[i].stop_cyc, vecs[i].busy_start,
                 1'b0, '0, '0, 1'b0, done_at, rise_at);
            chk($sformatf("vec%0d_done_cycle", i), done_at, vecs[i].exp_done);
            chk($sformatf("vec%0d_first_rise", i), rise_at, vecs[i].exp_rise);
            repeat (2) @(posedge clk);
            #1;
        end

        // back-to-back: second start lands in the done cycle of the first
        play(18'd8, 16'd1, 0, 0, 1'b1, 18'd12, 16'd2, 1'b0, done_at, rise_at);
        chk("b2b_first_done", done_at, 21);
        play(18'd12, 16'd2, 0, 0, 1'b0, '0, '0, 1'b1, done_at, rise_at);
        chk("b2b_second_done", done_at, 31);
        chk("b2b_second_rise", rise_at, 7);

        // reset mid-PLAY while speaker is high
        if0.note = 18'd8; if0.duration_ms = 16'd3; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pre_speaker", int'(spk0), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_post_outputs", int'({if0.busy, if0.done, spk0}), 0);
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            dones += int'(if0.done) + int'(if0.busy) + int'(spk0);
        end
        chk("rst_stays_idle", dones, 0);
        @(posedge clk); #1;

        // GAP_MS=0 instance: zero duration completes immediately without busy
        if1.duration_ms = 16'd0; if1.note = 18'd6; if1.start = 1'b1;
        @(negedge clk);
        chk("zero_c0_busy", int'(if1.busy), 0);
        @(posedge clk); #1;
        if1.start = 1'b0;
        @(negedge clk);
        chk("zero_c1_busy_done", int'({if1.busy, if1.done}), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_c2_done", int'(if1.done), 0);
        @(posedge clk); #1;
        if1.duration_ms = 16'd1; if1.note = 18'd4; if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] e;
            @(negedge clk);
            e = model(18'd4, 1, 0, k, 0);
            chk($sformatf("nogap_cycle%0d", k), int'({if1.busy, if1.done, spk1}), int'(e));
            @(posedge clk); #1;
        end

        for (int r = 0; r < 25; r++) begin
            rn  = ($urandom_range(0, 4) == 0) ? 18'($urandom_range(0, 200)) : 18'($urandom_range(0, 24));
            rd  = 16'($urandom_range(0, 4));
            tot = int'(rd) * T + G * T;
            sc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot) : 0;
            bs  = (sc > 0) ? $urandom_range(1, sc) : $urandom_range(1, tot);
            play(rn, rd, sc, bs, 1'b0, '0, '0, 1'b0, done_at, rise_at);
            chk($sformatf("rand%0d_done", r), done_at, (sc > 0) ? -1 : tot + 1);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Sequential stage directly downstream of the scale decoder.
- Accepts an 18-bit note period, given in clock cycles, plus a duration in milliseconds.
- Drives a square wave onto the speaker pin for that duration, then holds a fixed silent gap, then pulses done.
- The game sequencer issues notes one at a time through a start/busy/done handshake.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TICKS_PER_MS, CLK_HZ/1000, clock cycles per millisecond. Overridable, e.g. 10 for simulation.
- DUR_W, 16, width of duration_ms.
- GAP_MS, 50, silent gap in ms after every note. 0 means no gap.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- note  input  18  full square-wave period in clk cycles. 0 means rest.
- duration_ms  input  DUR_W  note length in ms.
- start  input  1  request. Sampled on clk edge while idle.
- stop  input  1  abort current note/gap. No done is produced.
- busy  output  1  high in PLAY and GAP.
- done  output  1  one-cycle pulse when a note and its gap complete.
- speaker  output  1  square-wave audio output.

Behaviour:
- Reset values: synchronous, active-high; everything clears on the next edge where reset=1, including mid-note.
  - State IDLE.
  - busy=0, done=0, speaker=0.
  - All counters 0.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE:
  - If start=1 at an edge, latch the following and clear ms_tick_cnt and half_cnt:
    - half = note>>1.
    - dur = duration_ms.
  - Next state is PLAY, or GAP if duration_ms=0, or IDLE with done=1 if both duration_ms=0 and GAP_MS=0.
  - start is ignored whenever busy=1. Inputs are only sampled at start; later changes to note or duration_ms have no effect.
- PLAY:
  - Lasts exactly dur*TICKS_PER_MS cycles.
  - ms_tick_cnt counts 0..TICKS_PER_MS-1; on wrap, ms_cnt increments. Leave PLAY when ms_cnt reaches dur.
  - Tone: half_cnt counts 0..half-1. At the edge where half_cnt=half-1, speaker toggles and half_cnt returns to 0.
  - Output period is 2*half cycles, so an odd note truncates by one cycle.
  - The first toggle (0→1) happens half cycles after PLAY entry.
  - If half<1 (note=0 or 1), treat as a rest: speaker stays 0 while timing continues.
- GAP:
  - speaker=0 for exactly GAP_MS*TICKS_PER_MS cycles.
  - Then go to IDLE with done=1 for the first IDLE cycle.
- speaker is forced to 0 on leaving PLAY, including stop and reset, so there is never a stuck-high output.
- stop=1 in PLAY or GAP: next cycle IDLE, busy=0, speaker=0, done=0.
- stop=1 in IDLE is a no-op. If stop and start are both high in IDLE, start wins.
- Counters:
  - ms_cnt is DUR_W wide.
  - ms_tick_cnt is wide enough for TICKS_PER_MS-1.
  - half_cnt is 17 bits.
  - No counter ever wraps before its terminal compare.
- Back-to-back: start high during the done cycle is accepted, since the block is already IDLE. The next PLAY begins the following cycle.

Test Plan:
All cases use TICKS_PER_MS=10 and GAP_MS=1 unless stated.
1. Basic note: note=8, duration_ms=3, start high in cycle 0 → busy 1..40; speaker rises at cycle 5, toggles every 4 cycles through cycle 30; speaker 0 during cycles 31..40; done=1 only in cycle 41.
2. Rest: note=0, duration_ms=2 → speaker stays 0 throughout; busy for 20+10 cycles; done at cycle 31.
3. Odd period and zero duration: note=9 → toggle every 4 cycles (period 8). duration_ms=0 → PLAY skipped, busy cycles 1..10, done at cycle 11.
4. Abort: start note=8, duration_ms=5, stop pulsed in cycle 13 → cycle 14 busy=0, speaker=0, no done ever. A start while busy (cycle 7) is ignored; latched note is unchanged.
5. Back-to-back and reset: start asserted in the done cycle → new PLAY from the next cycle with the new note. reset pulsed mid-PLAY → next cycle all outputs 0 and state IDLE.
6. Zero-length corner: GAP_MS=0, duration_ms=0, start → done pulses in cycle 1; busy never asserts.
